// File: rtl/sb_msg_arbiter.sv
// Sideband message arbiter: two single-slot requesters share one sideband
// serializer, round-robin on contention, with a grant-to-done timeout.
package sb_msg_arbiter_pkg;
  localparam int unsigned MSG_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic [MSG_W-1:0]  msg;
    logic [DATA_W-1:0] data;
  } sb_msg_t;
endpackage

module sb_msg_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid_a,
  input  logic [3:0]  i_msg_a,
  input  logic [15:0] i_data_a,
  input  logic        i_valid_b,
  input  logic [3:0]  i_msg_b,
  input  logic [15:0] i_data_b,
  output logic        o_busy_a,
  output logic        o_busy_b,
  output logic        o_busy_negedge_a,
  output logic        o_busy_negedge_b,
  output logic        o_sb_valid,
  output logic [3:0]  o_sb_msg,
  output logic [15:0] o_sb_data,
  input  logic        i_sb_ready,
  input  logic        i_sb_done,
  output logic        o_timeout,
  output logic        o_overrun
);
  import sb_msg_arbiter_pkg::*;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  sb_msg_t [1:0]      slot_q, slot_d;
  logic               gnt_b_q, gnt_b_d;
  logic               last_b_q, last_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sb_valid_q, valid_d;
  sb_msg_t            pl_q, pl_d;
  logic [1:0]         neg_q, neg_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic               release_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               cnt_hit_c;
  logic [1:0]         req_v_c;
  sb_msg_t [1:0]      req_pl_c;

  assign cnt_inc_c   = cnt_q + 16'd1;
  assign cnt_hit_c   = (cnt_inc_c == (TIMEOUT - 16'd1));
  assign req_v_c     = {i_valid_b, i_valid_a};
  assign req_pl_c[0] = {i_msg_a, i_data_a};
  assign req_pl_c[1] = {i_msg_b, i_data_b};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant, timeout and slot bookkeeping
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    slot_d    = slot_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    cnt_d     = cnt_q;
    valid_d   = sb_valid_q;
    pl_d      = pl_q;
    neg_d     = 2'b00;
    timeout_d = 1'b0;
    overrun_d = overrun_q;
    release_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // The fairness pointer only moves when both requesters contend.
          gnt_b_d = pend_q[1] & (~pend_q[0] | ~last_b_q);
          if (&pend_q) begin
            last_b_d = gnt_b_d;
          end
          pl_d    = gnt_b_d ? slot_q[1] : slot_q[0];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_hit_c) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
          valid_d   = 1'b0;
          state_d   = IDLE;
        end else if (sb_valid_q && i_sb_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_inc_c;
          state_d = WAIT_DONE;
        end else begin
          valid_d = 1'b1;
          cnt_d   = cnt_inc_c;
        end
      end
      WAIT_DONE: begin
        if (i_sb_done) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end else if (cnt_hit_c) begin
          release_c = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (release_c) begin
      pend_d[gnt_b_q] = 1'b0;
      neg_d[gnt_b_q]  = 1'b1;
    end

    // A slot freed on this edge may be refilled on the same edge.
    for (int i = 0; i < 2; i++) begin
      if (req_v_c[i]) begin
        if (pend_d[i]) begin
          overrun_d = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          slot_d[i] = req_pl_c[i];
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      slot_q     <= '0;
      gnt_b_q    <= 1'b0;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      sb_valid_q <= 1'b0;
      pl_q       <= '0;
      neg_q      <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      slot_q     <= slot_d;
      gnt_b_q    <= gnt_b_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      sb_valid_q <= valid_d;
      pl_q       <= pl_d;
      neg_q      <= neg_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_busy_a         = pend_q[0];
  assign o_busy_b         = pend_q[1];
  assign o_busy_negedge_a = neg_q[0];
  assign o_busy_negedge_b = neg_q[1];
  assign o_sb_valid       = sb_valid_q;
  assign o_sb_msg         = pl_q.msg;
  assign o_sb_data        = pl_q.data;
  assign o_timeout        = timeout_q;
  assign o_overrun        = overrun_q;

endmodule

// File: doc/sb_msg_arbiter.md
SB_MSG_ARBITER -- requirements
Module: sb_msg_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd1000: cycles allowed from grant to i_sb_done before forced release.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_valid_a  in  1  one-cycle send request from TX point-test FSM (requester A).
REQ-005 i_msg_a  in  4  encoded sideband message of A, sampled with i_valid_a.
REQ-006 i_data_a  in  16  sideband data of A, sampled with i_valid_a.
REQ-007 i_valid_b, i_msg_b, i_data_b  in  1/4/16  same as REQ-004..006 for RX point-test FSM (requester B).
REQ-008 o_busy_a, o_busy_b  out  1  high while that requester's message is pending or in flight.
REQ-009 o_busy_negedge_a, o_busy_negedge_b  out  1  one-cycle pulse on completion of that requester's message.
REQ-010 o_sb_valid  out  1  message offered to sideband serializer.
REQ-011 o_sb_msg / o_sb_data  out  4/16  granted message and data, stable while o_sb_valid=1.
REQ-012 i_sb_ready  in  1  serializer accepts offered message when high with o_sb_valid.
REQ-013 i_sb_done  in  1  serializer finished transmitting the accepted message.
REQ-014 o_timeout  out  1  one-cycle pulse on forced release.
REQ-015 o_overrun  out  1  sticky; set when a requester pulses valid while its busy is high.

Function
REQ-016 Each requester has a pending slot {msg,data}; i_valid_x with slot empty captures i_msg_x/i_data_x; pending and o_busy_x high next cycle.
REQ-017 i_valid_x while o_busy_x=1 is dropped, slot unchanged, o_overrun set.
REQ-018 FSM states IDLE, SEND, WAIT_DONE.
REQ-019 IDLE: if any slot pending, grant one, load o_sb_msg/o_sb_data, go SEND with o_sb_valid=1 next cycle; else stay.
REQ-020 Arbitration round-robin: with both pending, grant goes to requester not granted last; after reset A has priority.
REQ-021 Latency: i_valid_x sampled at edge N with arbiter idle and other slot empty -> o_sb_valid=1 after edge N+2.
REQ-022 SEND: hold o_sb_valid, msg, data until i_sb_ready=1; on that edge o_sb_valid=0, go WAIT_DONE.
REQ-023 WAIT_DONE: on i_sb_done=1, clear granted slot, o_busy_x=0 and o_busy_negedge_x=1 for one cycle, go IDLE.
REQ-024 i_sb_done outside WAIT_DONE is ignored.
REQ-025 16-bit timeout counter clears on grant and counts each cycle in SEND and WAIT_DONE; reaching TIMEOUT-1 -> treated as i_sb_done (REQ-023) plus o_timeout pulse, o_sb_valid=0.
REQ-026 Completion and new i_valid_x of the same requester on the same edge: old completes (negedge pulse), new captured, o_busy_x stays 1, no overrun.
REQ-027 Non-granted requester's new valid while other is in flight captured normally; serviced after return to IDLE.
REQ-028 Minimum one IDLE cycle between consecutive grants.

Reset
REQ-029 rst_n=0 asynchronously: state IDLE, slots empty, counter 0, last-grant=B (A first), all outputs 0 including o_sb_msg=4'h0, o_sb_data=16'h0, o_overrun=0.
REQ-030 Reset mid-transfer aborts silently: no negedge pulse, no timeout pulse after release.

Verification
REQ-031 Single A: i_valid_a, msg=4'h3, data=16'hABCD, i_sb_ready tied 1, i_sb_done 3 cycles later -> o_busy_a at N+1, o_sb_valid with 4'h3/ABCD at N+2 for one cycle, o_busy_negedge_a one pulse, o_busy_a=0.
REQ-032 A and B same cycle (msg 4'h1 / 4'h2) -> A sent first, B second; repeat -> B first (round-robin).
REQ-033 i_sb_ready held 0 for 10 cycles -> o_sb_valid, msg, data stable all 10 cycles, accepted on cycle 11.
REQ-034 TIMEOUT=16, i_sb_done never -> o_timeout and o_busy_negedge_x pulse 15 cycles after grant; next pending serviced.
REQ-035 i_valid_a twice while busy -> o_overrun=1 sticky, first message transmitted unchanged.
REQ-036 rst_n low during WAIT_DONE -> all outputs 0 immediately; after release new request completes normally.
